pulse_shaper_tx: RTL and testbench

PULSE_SHAPER_TX -- requirements
Module: pulse_shaper_tx

---
 rtl/pulse_shaper_tx.sv | 112 +++++++++++
 tb/tb_pulse_shaper_tx.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pulse_shaper_tx.sv
// Turns single-cycle event requests into shaped pulses: HIGH_CYC cycles high, then at least LOW_CYC low.
// Events that arrive while a pulse is being shaped wait in a saturating counter.
module pulse_shaper_tx #(
   parameter int HIGH_CYC = 4,
   parameter int LOW_CYC  = 4,
   parameter int PEND_W   = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              evt_in,
   input  logic              clr,
   output logic              out,
   output logic              busy,
   output logic [PEND_W-1:0] pend_cnt,
   output logic              ovf
);

   localparam int MAX_CYC = (HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam logic [PEND_W-1:0] PEND_FULL = '1;
   localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(HIGH_CYC - 1);
   localparam logic [CNT_W-1:0]  LOW_LOAD  = CNT_W'(LOW_CYC - 1);

   typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;

   state_t             state;
   logic [CNT_W-1:0]   hold_cnt;
   logic               gap_end;
   logic               inc;
   logic               dec;
   logic               ovf_nx;
   logic [PEND_W-1:0]  pend_nx;

   // A simultaneous increment and decrement cancel, so a full queue with a
   // departing event accepts the new one without overflow.
   function automatic logic [PEND_W:0] pend_next(input logic [PEND_W-1:0] cnt,
                                                  input logic inc_i,
                                                  input logic dec_i);
      if (inc_i && !dec_i) begin
         if (cnt == PEND_FULL) return {1'b1, cnt};
         else                  return {1'b0, cnt + 1'b1};
      end else if (dec_i && !inc_i) begin
         return {1'b0, cnt - 1'b1};
      end else begin
         return {1'b0, cnt};
      end
   endfunction

   always_comb begin
      gap_end = (state == GAP) && (hold_cnt == '0);
      inc     = evt_in && (state != IDLE);
      dec     = (pend_cnt != '0) && (((state == IDLE) && !evt_in) || gap_end);
      {ovf_nx, pend_nx} = pend_next(pend_cnt, inc, dec);
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         out      <= 1'b0;
         hold_cnt <= '0;
         pend_cnt <= '0;
         ovf      <= 1'b0;
      end else if (clr) begin
         state    <= IDLE;
         out      <= 1'b0;
         hold_cnt <= '0;
         pend_cnt <= '0;
         ovf      <= 1'b0;
      end else begin
         pend_cnt <= pend_nx;
         ovf      <= ovf_nx;
         unique case (state)
            IDLE: begin
               if (evt_in || (pend_cnt != '0)) begin
                  state    <= HIGH;
                  out      <= 1'b1;
                  hold_cnt <= HIGH_LOAD;
               end
            end
            HIGH: begin
               if (hold_cnt == '0) begin
                  state    <= GAP;
                  out      <= 1'b0;
                  hold_cnt <= LOW_LOAD;
               end else begin
                  hold_cnt <= hold_cnt - 1'b1;
               end
            end
            GAP: begin
               if (hold_cnt == '0) begin
                  if (pend_cnt != '0) begin
                     state    <= HIGH;
                     out      <= 1'b1;
                     hold_cnt <= HIGH_LOAD;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  hold_cnt <= hold_cnt - 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               out   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pulse_shaper_tx.sv
// Bench for pulse_shaper_tx: phase/remaining-cycles model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_pulse_shaper_tx;

   localparam int HC   = 4;
   localparam int LC   = 4;
   localparam int PW   = 2;
   localparam int FULL = (1 << PW) - 1;

   logic          clk    = 1'b0;
   logic          rst_n  = 1'b0;
   logic          evt_in = 1'b0;
   logic          clr    = 1'b0;
   logic          out;
   logic          busy;
   logic          ovf;
   logic [PW-1:0] pend_cnt;

   int   errors   = 0;
   int   checks   = 0;
   int   pulses   = 0;
   int   ovf_seen = 0;
   logic prev_out = 1'b0;

   // Model: phase 0 idle, 1 high, 2 low gap; m_left = cycles left in phase.
   int   m_phase = 0;
   int   m_left  = 0;
   int   m_pend  = 0;
   logic m_ovf   = 1'b0;

   always #5 clk = ~clk;

   pulse_shaper_tx #(.HIGH_CYC(HC), .LOW_CYC(LC), .PEND_W(PW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .evt_in   (evt_in),
      .clr      (clr),
      .out      (out),
      .busy     (busy),
      .pend_cnt (pend_cnt),
      .ovf      (ovf)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic m_enqueue();
      if (m_pend == FULL) m_ovf = 1'b1;
      else                m_pend++;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase = 0; m_left = 0; m_pend = 0; m_ovf = 1'b0;
      end else begin
         m_ovf = 1'b0;
         if (clr) begin
            m_phase = 0; m_left = 0; m_pend = 0;
         end else begin
            case (m_phase)
               0: begin
                  if (evt_in) begin
                     m_phase = 1; m_left = HC;
                  end else if (m_pend > 0) begin
                     m_pend--; m_phase = 1; m_left = HC;
                  end
               end
               1: begin
                  if (evt_in) m_enqueue();
                  m_left--;
                  if (m_left == 0) begin m_phase = 2; m_left = LC; end
               end
               default: begin
                  m_left--;
                  if (m_left == 0) begin
                     if (m_pend > 0) begin m_pend--; m_phase = 1; m_left = HC; end
                     else m_phase = 0;
                  end
                  if (evt_in) m_enqueue();
               end
            endcase
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("model_out",  out,      m_phase == 1);
         chk("model_busy", busy,     m_phase != 0);
         chk("model_pend", pend_cnt, m_pend);
         chk("model_ovf",  ovf,      m_ovf);
         if (out && !prev_out) pulses++;
         if (ovf) ovf_seen++;
      end
      prev_out = out;
   end

   int exp_pend[6] = '{0, 1, 2, 3, 3, 3};
   int exp_ovf[6]  = '{0, 0, 0, 0, 1, 1};

   initial begin
      step(2);
      chk("rst_out", out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_pend", pend_cnt, 0);
      chk("rst_ovf", ovf, 0);
      rst_n = 1'b1;
      step(3);

      // Single pulse: 4 high, 4 low, then idle.
      pulses = 0;
      evt_in = 1'b1; step(1); evt_in = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("single_out", out, (i < 4) ? 1 : 0);
         chk("single_busy", busy, 1);
         chk("single_pend", pend_cnt, 0);
         step(1);
      end
      chk("single_idle", busy, 0);
      chk("single_pulses", pulses, 1);

      // Burst of three consecutive events.
      pulses = 0;
      evt_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(1);
         chk("burst_pend", pend_cnt, i);
      end
      evt_in = 1'b0;
      step(30);
      chk("burst_pulses", pulses, 3);
      chk("burst_end_pend", pend_cnt, 0);

      // Overflow: six events into a 2-bit queue.
      pulses = 0; ovf_seen = 0;
      evt_in = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step(1);
         chk("ovf_pend", pend_cnt, exp_pend[i]);
         chk("ovf_flag", ovf, exp_ovf[i]);
      end
      evt_in = 1'b0;
      step(40);
      chk("ovf_pulses", pulses, 4);
      chk("ovf_count", ovf_seen, 2);

      // Event on the gap-end edge with one event pending.
      pulses = 0;
      evt_in = 1'b1; step(2); evt_in = 1'b0;
      chk("coin_pend_before", pend_cnt, 1);
      step(6);
      evt_in = 1'b1; step(1); evt_in = 1'b0;
      chk("coin_pend", pend_cnt, 1);
      chk("coin_out", out, 1);
      step(30);
      chk("coin_pulses", pulses, 3);

      // Clear during a high phase, colliding with a new event.
      pulses = 0;
      evt_in = 1'b1; step(3);
      chk("clr_pre_pend", pend_cnt, 2);
      chk("clr_pre_out", out, 1);
      clr = 1'b1; step(1); clr = 1'b0; evt_in = 1'b0;
      chk("clr_out", out, 0);
      chk("clr_busy", busy, 0);
      chk("clr_pend", pend_cnt, 0);
      chk("clr_ovf", ovf, 0);
      step(12);
      chk("clr_pulses", pulses, 1);

      // Reset in the middle of a gap with a full queue.
      pulses = 0;
      evt_in = 1'b1; step(4); evt_in = 1'b0;
      chk("rst_pre_pend", pend_cnt, 3);
      step(2);
      chk("rst_pre_gap", out, 0);
      chk("rst_pre_busy", busy, 1);
      rst_n = 1'b0; #1;
      chk("mid_rst_out", out, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_pend", pend_cnt, 0);
      chk("mid_rst_ovf", ovf, 0);
      step(1);
      rst_n = 1'b1;
      step(15);
      chk("post_rst_pulses", pulses, 1);
      chk("post_rst_busy", busy, 0);
      evt_in = 1'b1; step(1); evt_in = 1'b0;
      chk("post_rst_latency", out, 1);
      step(10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
